// File: rtl/wb_ram_responder.sv
// +----------------------------------------------------------------------------+
// | wb_ram_responder: Wishbone B3 word-RAM responder with wait states, ERR on   |
// | out-of-window access, optional CTI linear bursts (WB_RAM_RESPONDER_BURST_EN)|
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module wb_ram_responder #(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter logic [29:0] BASE_ADDR   = 30'h0,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        CLK_I,
  input  logic        RST_I,
  input  logic        CYC_I,
  input  logic        STB_I,
  input  logic        WE_I,
  input  logic [29:0] ADR_I,
  input  logic [3:0]  SEL_I,
  input  logic [31:0] DAT_I,
  input  logic [2:0]  CTI_I,
  input  logic [1:0]  BTE_I,
  output logic [31:0] DAT_O,
  output logic        ACK_O,
  output logic        ERR_O,
  output logic        RTY_O
);

  localparam int unsigned C_DEPTH   = 1 << ADDR_WIDTH;
  localparam logic [3:0]  C_WS_LOAD = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_ACK,
    S_ERR
`ifdef WB_RAM_RESPONDER_BURST_EN
    , S_BURST
`endif
  } state_t;

  state_t                  state_q;
  logic                    ack_q;
  logic                    err_q;
  logic [31:0]             dat_q;
  logic [3:0]              wcnt_q;
  logic [31:0]             mem_q [C_DEPTH];

  logic                    w_req;
  logic [29:0]             w_off;
  logic                    w_in_range;
  logic [ADDR_WIDTH-1:0]   w_idx;
  logic                    w_wr;
  logic [ADDR_WIDTH-1:0]   w_waddr;

  assign w_req      = CYC_I & STB_I;
  // Subtract wraps in 30 bits so addresses below BASE_ADDR land out of range.
  assign w_off      = ADR_I - BASE_ADDR;
  assign w_in_range = ((w_off >> ADDR_WIDTH) == '0);
  assign w_idx      = w_off[ADDR_WIDTH-1:0];

`ifdef WB_RAM_RESPONDER_BURST_EN
  logic [ADDR_WIDTH-1:0]   baddr_q;
  logic [ADDR_WIDTH-1:0]   baddr_d;
  logic [ADDR_WIDTH-1:0]   w_idx_nxt;
  logic                    w_burst_go;

  assign baddr_d    = baddr_q + ADDR_WIDTH'(1);
  assign w_idx_nxt  = w_idx + ADDR_WIDTH'(1);
  assign w_burst_go = w_req && (CTI_I == 3'b010) && (BTE_I == 2'b00)
                      && w_in_range && !(&w_idx);
`else
  logic w_unused;
  assign w_unused = ^{CTI_I, BTE_I};
`endif

  always_comb begin
    w_wr    = 1'b0;
    w_waddr = w_idx;
    if (w_req && WE_I && ack_q && !RST_I) begin
      if (state_q == S_ACK) begin
        w_wr = 1'b1;
      end
`ifdef WB_RAM_RESPONDER_BURST_EN
      else if (state_q == S_BURST) begin
        w_wr    = 1'b1;
        w_waddr = baddr_q;
      end
`endif
    end
  end

  always_ff @(posedge CLK_I) begin
    if (w_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (SEL_I[b]) mem_q[w_waddr][8*b +: 8] <= DAT_I[8*b +: 8];
      end
    end
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state_q <= S_IDLE;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      dat_q   <= '0;
      wcnt_q  <= '0;
`ifdef WB_RAM_RESPONDER_BURST_EN
      baddr_q <= '0;
`endif
    end else if (!CYC_I) begin
      state_q <= S_IDLE;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (w_req) begin
            if (!w_in_range) begin
              state_q <= S_ERR;
              err_q   <= 1'b1;
            end else if (WAIT_STATES == 0) begin
              state_q <= S_ACK;
              ack_q   <= 1'b1;
              dat_q   <= mem_q[w_idx];
            end else begin
              state_q <= S_WAIT;
              wcnt_q  <= C_WS_LOAD;
            end
          end
        end
        S_WAIT: begin
          if (!w_req) begin
            state_q <= S_IDLE;
          end else if (wcnt_q == 4'd0) begin
            state_q <= S_ACK;
            ack_q   <= 1'b1;
            dat_q   <= mem_q[w_idx];
          end else begin
            wcnt_q <= wcnt_q - 4'd1;
          end
        end
        S_ACK: begin
`ifdef WB_RAM_RESPONDER_BURST_EN
          if (w_burst_go) begin
            state_q <= S_BURST;
            baddr_q <= w_idx_nxt;
            dat_q   <= mem_q[w_idx_nxt];
          end else
`endif
          begin
            state_q <= S_IDLE;
            ack_q   <= 1'b0;
          end
        end
`ifdef WB_RAM_RESPONDER_BURST_EN
        S_BURST: begin
          if (!w_req) begin
            ack_q <= 1'b0;
          end else if (!ack_q) begin
            // Resuming after a strobe gap: the pending beat was never taken.
            ack_q <= 1'b1;
            dat_q <= mem_q[baddr_q];
          end else if (CTI_I == 3'b111) begin
            state_q <= S_IDLE;
            ack_q   <= 1'b0;
          end else if (&baddr_q) begin
            state_q <= S_ERR;
            ack_q   <= 1'b0;
            err_q   <= 1'b1;
          end else begin
            baddr_q <= baddr_d;
            dat_q   <= mem_q[baddr_d];
          end
        end
`endif
        S_ERR: begin
          state_q <= S_IDLE;
          err_q   <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          ack_q   <= 1'b0;
          err_q   <= 1'b0;
        end
      endcase
    end
  end

  assign DAT_O = dat_q;
  assign ACK_O = ack_q;
  assign ERR_O = err_q;
  assign RTY_O = 1'b0;

endmodule

`default_nettype wire
